// File: rtl/my_micro_sequencer.sv
// Micro-PC sequencer with programmable opcode/funct dispatch table; outputs registered, one-cycle latency.
// i_stall holds micro-PC and flags while table writes still proceed; no combinational input-to-output path.
module my_micro_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int OP_W         = 6,
  parameter int FUNCT_W      = 6,
  parameter int N_ENTRY      = 8,
  parameter int FETCH_ADDR   = 0,
  parameter int ILLEGAL_ADDR = 2**ADDR_W-1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [OP_W-1:0]            i_op,
  input  logic [FUNCT_W-1:0]         i_funct,
  input  logic [1:0]                 i_addr_ctrl,
  input  logic [ADDR_W-1:0]          i_jump_addr,
  input  logic                       i_stall,
  input  logic                       i_wr_en,
  input  logic [$clog2(N_ENTRY)-1:0] i_wr_idx,
  input  logic [OP_W-1:0]            i_wr_op,
  input  logic [FUNCT_W-1:0]         i_wr_funct,
  input  logic                       i_wr_funct_care,
  input  logic                       i_wr_valid,
  input  logic [ADDR_W-1:0]          i_wr_target,
  output logic [ADDR_W-1:0]          o_upc,
  output logic                       o_illegal,
  output logic [$clog2(N_ENTRY)-1:0] o_hit_idx
);

  localparam int IDX_W = $clog2(N_ENTRY);

  typedef enum logic [1:0] {
    MODE_FETCH    = 2'b00,
    MODE_DISPATCH = 2'b01,
    MODE_NEXT     = 2'b10,
    MODE_JUMP     = 2'b11
  } mode_e;

  mode_e              mode;
  logic [N_ENTRY-1:0] tbl_vld;
  logic [N_ENTRY-1:0] tbl_care;
  logic [OP_W-1:0]    tbl_op    [N_ENTRY];
  logic [FUNCT_W-1:0] tbl_funct [N_ENTRY];
  logic [ADDR_W-1:0]  tbl_tgt   [N_ENTRY];

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [ADDR_W-1:0]  hit_tgt;
  logic [ADDR_W-1:0]  upc_nxt;
  logic               dispatch;

  assign mode     = mode_e'(i_addr_ctrl);
  assign dispatch = (mode == MODE_DISPATCH);

  // Scan from the top so the lowest matching index is the last assignment and wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_tgt = '0;
    for (int k = N_ENTRY-1; k >= 0; k--) begin
      if (tbl_vld[k] && (tbl_op[k] == i_op) &&
          (!tbl_care[k] || (tbl_funct[k] == i_funct))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
        hit_tgt = tbl_tgt[k];
      end
    end
  end

  always_comb begin
    upc_nxt = ADDR_W'(FETCH_ADDR);
    case (mode)
      MODE_FETCH:    upc_nxt = ADDR_W'(FETCH_ADDR);
      MODE_DISPATCH: upc_nxt = hit ? hit_tgt : ADDR_W'(ILLEGAL_ADDR);
      MODE_NEXT:     upc_nxt = o_upc + ADDR_W'(1);
      MODE_JUMP:     upc_nxt = i_jump_addr;
      default:       upc_nxt = ADDR_W'(FETCH_ADDR);
    endcase
  end

  // Out-of-range write indices match no entry and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tbl_vld  <= '0;
      tbl_care <= '0;
      for (int k = 0; k < N_ENTRY; k++) begin
        tbl_op[k]    <= '0;
        tbl_funct[k] <= '0;
        tbl_tgt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_ENTRY; k++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
          tbl_vld[k]   <= i_wr_valid;
          tbl_care[k]  <= i_wr_funct_care;
          tbl_op[k]    <= i_wr_op;
          tbl_funct[k] <= i_wr_funct;
          tbl_tgt[k]   <= i_wr_target;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_upc     <= ADDR_W'(FETCH_ADDR);
      o_illegal <= 1'b0;
      o_hit_idx <= '0;
    end else if (!i_stall) begin
      o_upc     <= upc_nxt;
      o_illegal <= dispatch && !hit;
      if (dispatch && hit) o_hit_idx <= hit_idx;
    end
  end

endmodule

// File: tb/tb_my_micro_sequencer.sv
// Directed self-checking bench for my_micro_sequencer (6-entry table so out-of-range indices are reachable).
module tb_my_micro_sequencer;

  localparam logic [1:0] FETCH = 2'b00, DISP = 2'b01, NEXT = 2'b10, JUMP = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] i_op, i_funct;
  logic [1:0] i_addr_ctrl;
  logic [7:0] i_jump_addr;
  logic       i_stall;
  logic       i_wr_en;
  logic [2:0] i_wr_idx;
  logic [5:0] i_wr_op, i_wr_funct;
  logic       i_wr_funct_care, i_wr_valid;
  logic [7:0] i_wr_target;
  logic [7:0] o_upc;
  logic       o_illegal;
  logic [2:0] o_hit_idx;

  int errors = 0;
  int checks = 0;

  my_micro_sequencer #(.N_ENTRY(6)) dut (
    .clk(clk), .reset_n(reset_n), .i_op(i_op), .i_funct(i_funct),
    .i_addr_ctrl(i_addr_ctrl), .i_jump_addr(i_jump_addr), .i_stall(i_stall),
    .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_op(i_wr_op), .i_wr_funct(i_wr_funct),
    .i_wr_funct_care(i_wr_funct_care), .i_wr_valid(i_wr_valid), .i_wr_target(i_wr_target),
    .o_upc(o_upc), .o_illegal(o_illegal), .o_hit_idx(o_hit_idx)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
  endtask

  task automatic mode(input logic [1:0] ctrl, input logic [5:0] op, input logic [5:0] funct,
                      input logic [7:0] jaddr);
    i_addr_ctrl = ctrl;
    i_op        = op;
    i_funct     = funct;
    i_jump_addr = jaddr;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [5:0] op, input logic [5:0] funct,
                    input logic care, input logic valid, input logic [7:0] tgt);
    i_wr_en         = 1'b1;
    i_wr_idx        = idx;
    i_wr_op         = op;
    i_wr_funct      = funct;
    i_wr_funct_care = care;
    i_wr_valid      = valid;
    i_wr_target     = tgt;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_stall = 1'b0; i_wr_en = 1'b0; i_wr_idx = '0; i_wr_op = '0;
    i_wr_funct = '0; i_wr_funct_care = 1'b0; i_wr_valid = 1'b0; i_wr_target = '0;
    mode(FETCH, 6'h00, 6'h00, 8'h00);
    #12;
    checks++; if (o_upc !== 8'h00) begin errors++; $display("FAIL rst_upc got %h exp 00", o_upc); end
    checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", o_illegal); end
    checks++; if (o_hit_idx !== 3'd0) begin errors++; $display("FAIL rst_hit_idx got %0d exp 0", o_hit_idx); end
    reset_n = 1'b1;
    step();
    mode(DISP, 6'h05, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL rst_empty_disp got upc=%h ill=%b exp upc=ff ill=1", o_upc, o_illegal); end
  endtask

  task automatic test_reset_mid();
    mode(FETCH, 6'h00, 6'h00, 8'h00); wr(3'd3, 6'h05, 6'h00, 1'b0, 1'b1, 8'h30); step();
    mode(DISP, 6'h05, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'h30 || o_hit_idx !== 3'd3) begin errors++;
      $display("FAIL mid_pre_hit got upc=%h idx=%0d exp upc=30 idx=3", o_upc, o_hit_idx); end
    mode(JUMP, 6'h00, 6'h00, 8'h23); step();
    checks++; if (o_upc !== 8'h23) begin errors++; $display("FAIL mid_jump got %h exp 23", o_upc); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_upc !== 8'h00 || o_illegal !== 1'b0 || o_hit_idx !== 3'd0) begin errors++;
      $display("FAIL mid_async got upc=%h ill=%b idx=%0d exp 00 0 0", o_upc, o_illegal, o_hit_idx); end
    #1 reset_n = 1'b1;
    mode(DISP, 6'h05, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL mid_table_cleared got upc=%h ill=%b exp ff 1", o_upc, o_illegal); end
  endtask

  task automatic test_funct_priority();
    mode(FETCH, 6'h00, 6'h00, 8'h00);
    wr(3'd0, 6'h00, 6'h20, 1'b1, 1'b1, 8'h10); step();
    wr(3'd1, 6'h00, 6'h00, 1'b0, 1'b1, 8'h18); step();
    mode(DISP, 6'h00, 6'h20, 8'h00); step();
    checks++; if (o_upc !== 8'h10 || o_hit_idx !== 3'd0 || o_illegal !== 1'b0) begin errors++;
      $display("FAIL fp_exact got upc=%h idx=%0d ill=%b exp 10 0 0", o_upc, o_hit_idx, o_illegal); end
    mode(DISP, 6'h00, 6'h22, 8'h00); step();
    checks++; if (o_upc !== 8'h18 || o_hit_idx !== 3'd1) begin errors++;
      $display("FAIL fp_masked got upc=%h idx=%0d exp 18 1", o_upc, o_hit_idx); end
  endtask

  task automatic test_sequencing();
    mode(JUMP, 6'h00, 6'h00, 8'hFE); step();
    checks++; if (o_upc !== 8'hFE) begin errors++; $display("FAIL seq_jump got %h exp fe", o_upc); end
    mode(NEXT, 6'h00, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'hFF) begin errors++; $display("FAIL seq_next1 got %h exp ff", o_upc); end
    step();
    checks++; if (o_upc !== 8'h00 || o_illegal !== 1'b0) begin errors++;
      $display("FAIL seq_wrap got upc=%h ill=%b exp 00 0", o_upc, o_illegal); end
    step();
    checks++; if (o_upc !== 8'h01) begin errors++; $display("FAIL seq_next3 got %h exp 01", o_upc); end
    mode(FETCH, 6'h00, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'h00) begin errors++; $display("FAIL seq_fetch got %h exp 00", o_upc); end
  endtask

  task automatic test_stall();
    mode(DISP, 6'h00, 6'h20, 8'h00); step();
    checks++; if (o_upc !== 8'h10 || o_hit_idx !== 3'd0) begin errors++;
      $display("FAIL st_setup got upc=%h idx=%0d exp 10 0", o_upc, o_hit_idx); end
    i_stall = 1'b1;
    mode(DISP, 6'h3F, 6'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (o_upc !== 8'h10 || o_illegal !== 1'b0) begin errors++;
        $display("FAIL st_hold%0d got upc=%h ill=%b exp 10 0", c, o_upc, o_illegal); end
    end
    mode(DISP, 6'h00, 6'h22, 8'h00); step();
    checks++; if (o_hit_idx !== 3'd0 || o_upc !== 8'h10) begin errors++;
      $display("FAIL st_hit_hold got idx=%0d upc=%h exp 0 10", o_hit_idx, o_upc); end
    i_stall = 1'b0;
    mode(DISP, 6'h3F, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL st_release got upc=%h ill=%b exp ff 1", o_upc, o_illegal); end
    i_stall = 1'b1;
    mode(NEXT, 6'h00, 6'h00, 8'h00); step(); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL st_ill_held got upc=%h ill=%b exp ff 1", o_upc, o_illegal); end
    i_stall = 1'b0; step();
    checks++; if (o_upc !== 8'h00 || o_illegal !== 1'b0) begin errors++;
      $display("FAIL st_next got upc=%h ill=%b exp 00 0", o_upc, o_illegal); end
  endtask

  task automatic test_back_to_back();
    mode(DISP, 6'h23, 6'h00, 8'h00); wr(3'd2, 6'h23, 6'h00, 1'b0, 1'b1, 8'h40); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL col_same_cycle got upc=%h ill=%b exp ff 1", o_upc, o_illegal); end
    step();
    checks++; if (o_upc !== 8'h40 || o_hit_idx !== 3'd2 || o_illegal !== 1'b0) begin errors++;
      $display("FAIL col_next_cycle got upc=%h idx=%0d ill=%b exp 40 2 0", o_upc, o_hit_idx, o_illegal); end
    i_stall = 1'b1;
    mode(FETCH, 6'h00, 6'h00, 8'h00); wr(3'd4, 6'h11, 6'h00, 1'b0, 1'b1, 8'h50); step();
    checks++; if (o_upc !== 8'h40) begin errors++; $display("FAIL wst_hold got %h exp 40", o_upc); end
    i_stall = 1'b0;
    mode(DISP, 6'h11, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'h50 || o_hit_idx !== 3'd4) begin errors++;
      $display("FAIL wst_visible got upc=%h idx=%0d exp 50 4", o_upc, o_hit_idx); end
  endtask

  task automatic test_out_of_range();
    mode(FETCH, 6'h00, 6'h00, 8'h00);
    wr(3'd6, 6'h2A, 6'h00, 1'b0, 1'b1, 8'h60); step();
    wr(3'd7, 6'h23, 6'h00, 1'b0, 1'b1, 8'h70); step();
    mode(DISP, 6'h2A, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin errors++;
      $display("FAIL oor_ignored got upc=%h ill=%b exp ff 1", o_upc, o_illegal); end
    mode(DISP, 6'h23, 6'h00, 8'h00); step();
    checks++; if (o_upc !== 8'h40 || o_hit_idx !== 3'd2) begin errors++;
      $display("FAIL oor_intact got upc=%h idx=%0d exp 40 2", o_upc, o_hit_idx); end
    mode(FETCH, 6'h00, 6'h00, 8'h00); wr(3'd0, 6'h00, 6'h20, 1'b1, 1'b0, 8'h10); step();
    mode(DISP, 6'h00, 6'h20, 8'h00); step();
    checks++; if (o_upc !== 8'h18 || o_hit_idx !== 3'd1) begin errors++;
      $display("FAIL inv_fallthrough got upc=%h idx=%0d exp 18 1", o_upc, o_hit_idx); end
    mode(FETCH, 6'h00, 6'h00, 8'h00); wr(3'd1, 6'h00, 6'h00, 1'b0, 1'b0, 8'h18); step();
    mode(DISP, 6'h00, 6'h20, 8'h00); step();
    checks++; if (o_upc !== 8'hFF || o_illegal !== 1'b1 || o_hit_idx !== 3'd1) begin errors++;
      $display("FAIL inv_miss got upc=%h ill=%b idx=%0d exp ff 1 1", o_upc, o_illegal, o_hit_idx); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_funct_priority();
    test_sequencing();
    test_stall();
    test_back_to_back();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
